// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: frame geometry and the transmit FSM state encoding.
package spi_pkg;

  localparam int unsigned SPI_DATA_W   = 16;
  localparam int unsigned SPI_HDR_BITS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus history flop, giving one-clk rise/fall pulses of an async input.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  // [0],[1] synchronize; [2] holds the previous synchronized value
  logic [2:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= {3{RESET_VAL}};
    else       sync_q <= {sync_q[1:0], din};
  end

  assign rise =  sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/spi_miso_tx.sv
// SPI slave read-data transmitter: loads a word on tx_req and shifts it out MSB first on MISO (CPOL=0).
module spi_miso_tx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_req,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              sclk,
  input  logic              ssn,
  output logic              miso,
  output logic              miso_oe,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_abort
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              sclk_rise, sclk_fall, ssn_rise;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_ssn_sync (
    .clk   (clk),
    .reset (reset),
    .din   (ssn),
    .rise  (ssn_rise),
    .fall  ()
  );

  // miso is the shift register MSB flop; shreg is cleared on leaving SHIFT so miso idles at 0
  assign miso = shreg[DATA_W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      miso_oe  <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_req) begin
            shreg   <= tx_data;
            bit_cnt <= '0;
            miso_oe <= 1'b1;
            tx_busy <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (ssn_rise) begin
            shreg    <= '0;
            miso_oe  <= 1'b0;
            tx_busy  <= 1'b0;
            tx_abort <= 1'b1;
            state    <= IDLE;
          end else begin
            if (sclk_rise && (bit_cnt < CNT_MAX)) bit_cnt <= bit_cnt + CNT_W'(1);
            if (sclk_fall) begin
              if (bit_cnt < CNT_MAX) begin
                shreg <= {shreg[DATA_W-2:0], 1'b0};
              end else begin
                shreg   <= '0;
                miso_oe <= 1'b0;
                tx_busy <= 1'b0;
                tx_done <= 1'b1;
                state   <= DONE;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_miso_tx.sv
// Scoreboard bench for spi_miso_tx: expected MISO bits are queued per SPI rising edge and checked by a monitor.
module tb_spi_miso_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_req = 1'b0;
  logic [15:0] tx_data = '0;
  logic        sclk = 1'b0;
  logic        ssn = 1'b1;
  logic        miso, miso_oe, tx_busy, tx_done, tx_abort;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  typedef struct packed {
    logic miso;
    logic oe;
  } exp_t;
  exp_t exp_q[$];

  spi_miso_tx #(.DATA_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .sclk     (sclk),
    .ssn      (ssn),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_abort (tx_abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Master-side sampling: every SPI rising edge consumes one expected entry
  initial begin
    exp_t e;
    forever begin
      @(posedge sclk);
      if (exp_q.size() == 0) begin
        check("unexpected_sclk_rise", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("miso_bit", {31'd0, miso}, {31'd0, e.miso});
        check("miso_oe_at_rise", {31'd0, miso_oe}, {31'd0, e.oe});
      end
    end
  end

  // Pulse monitor: counts done/abort cycles and checks pad state during them
  initial begin
    forever begin
      @(negedge clk);
      if (tx_done) begin
        done_cnt++;
        check("done_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("done_miso", {31'd0, miso}, 32'd0);
        check("done_busy", {31'd0, tx_busy}, 32'd0);
      end
      if (tx_abort) begin
        abort_cnt++;
        check("abort_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("abort_done_overlap", {31'd0, tx_done}, 32'd0);
      end
    end
  end

  task automatic send_req(input logic [15:0] d);
    @(negedge clk);
    tx_req  = 1'b1;
    tx_data = d;
    @(negedge clk);
    tx_req  = 1'b0;
    tx_data = $urandom();
  endtask

  task automatic sclk_pulse();
    sclk = 1'b1;
    #50;
    sclk = 1'b0;
    #50;
  endtask

  // Reference: bit k of a frame (k=0 first) is data[15-k]; pad is enabled throughout
  task automatic frame_bits(input logic [15:0] d, input int first, input int last);
    exp_t e;
    for (int k = first; k <= last; k++) begin
      e.miso = (d >> (15 - k)) & 16'd1;
      e.oe   = 1'b1;
      exp_q.push_back(e);
      sclk_pulse();
    end
  endtask

  task automatic idle_bits(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e = '0;
      exp_q.push_back(e);
      sclk_pulse();
    end
  endtask

  task automatic run_frame(input logic [15:0] d, input string tag);
    int d0;
    d0 = done_cnt;
    ssn = 1'b0;
    repeat (4) @(negedge clk);
    send_req(d);
    @(negedge clk);
    check({tag, "_first_bit"}, {31'd0, miso}, {31'd0, d[15]});
    check({tag, "_busy"}, {31'd0, tx_busy}, 32'd1);
    repeat (5 + $urandom_range(0, 5)) @(negedge clk);
    frame_bits(d, 0, 15);
    repeat (5) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
    check({tag, "_oe_after"}, {31'd0, miso_oe}, 32'd0);
    ssn = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int d0, a0;

    repeat (3) @(negedge clk);
    check("rst_outputs", {27'd0, miso, miso_oe, tx_busy, tx_done, tx_abort}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_outputs", {27'd0, miso, miso_oe, tx_busy, tx_done, tx_abort}, 32'd0);

    run_frame(16'hA5C3, "a5c3");

    // Abort after five rises
    d0 = done_cnt; a0 = abort_cnt;
    ssn = 1'b0;
    repeat (3) @(negedge clk);
    send_req(16'h8001);
    repeat (6) @(negedge clk);
    frame_bits(16'h8001, 0, 4);
    ssn = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_pulses", abort_cnt - a0, 32'd1);
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_idle", {30'd0, miso_oe, tx_busy}, 32'd0);

    // Second request mid-frame must be ignored
    ssn = 1'b0;
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    send_req(16'h0000);
    repeat (6) @(negedge clk);
    frame_bits(16'h0000, 0, 6);
    send_req(16'hFFFF);
    repeat (3) @(negedge clk);
    frame_bits(16'h0000, 7, 15);
    repeat (5) @(negedge clk);
    check("ignored_req_done", done_cnt - d0, 32'd1);
    ssn = 1'b1;
    repeat (6) @(negedge clk);

    // Reset mid-frame
    d0 = done_cnt; a0 = abort_cnt;
    ssn = 1'b0;
    repeat (3) @(negedge clk);
    send_req(16'h1234);
    repeat (6) @(negedge clk);
    frame_bits(16'h1234, 0, 8);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_outputs", {27'd0, miso, miso_oe, tx_busy, tx_done, tx_abort}, 32'd0);
    ssn = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_no_pulses", (done_cnt - d0) + (abort_cnt - a0), 32'd0);
    run_frame(16'h00FF, "after_rst");

    run_frame(16'h0001, "b2b_a");
    run_frame(16'h8000, "b2b_b");

    // SPI clock activity with nothing loaded
    d0 = done_cnt;
    ssn = 1'b1;
    idle_bits(6);
    ssn = 1'b0;
    idle_bits(4);
    ssn = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_done", done_cnt - d0, 32'd0);
    check("idle_outputs", {30'd0, miso, miso_oe}, 32'd0);

    for (int i = 0; i < 6; i++) run_frame(16'($urandom()), "random");

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/spi_miso_tx.md
SPI_MISO_TX -- requirements
Module: spi_miso_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the number of read-data bits per frame, sent MSB first.
REQ-002 The block SHALL have port clk, input, 1 bit, system clock at 100 MHz.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset; reset reset, asynchronous, active-high; clock clk.
REQ-004 The block SHALL have port tx_req, input, 1 bit, one-clk pulse from the SPI receiver at the end of the 16-bit command header.
REQ-005 The block SHALL have port tx_data, input, DATA_W bits, register read data, valid in the same cycle as tx_req.
REQ-006 The block SHALL have port sclk, input, 1 bit, asynchronous SPI clock at 10 MHz, CPOL=0.
REQ-007 The block SHALL have port ssn, input, 1 bit, asynchronous slave select, active-low.
REQ-008 The block SHALL have port miso, output, 1 bit, registered serial data.
REQ-009 The block SHALL have port miso_oe, output, 1 bit, MISO pad output enable, 1 only while transmitting.
REQ-010 The block SHALL have port tx_busy, output, 1 bit, high from load until DONE or abort.
REQ-011 The block SHALL have port tx_done, output, 1 bit, one-clk pulse when all DATA_W bits have been shifted out.
REQ-012 The block SHALL have port tx_abort, output, 1 bit, one-clk pulse when ssn deasserts mid-frame.

Function
REQ-013 The block SHALL synchronize sclk and ssn through 2 flops plus 1 history flop, producing one-clk pulses sclk_rise, sclk_fall and ssn_rise.
REQ-014 The block SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 In IDLE, a tx_req at a clk edge SHALL load shreg=tx_data and bit_cnt=0, and SHALL give miso=tx_data[DATA_W-1], miso_oe=1, tx_busy=1 from the next cycle; state goes to SHIFT.
REQ-016 In SHIFT, each sclk_rise SHALL increment bit_cnt, where bit_cnt is $clog2(DATA_W)+1 bits wide and saturates at DATA_W.
REQ-017 In SHIFT, each sclk_fall with bit_cnt<DATA_W SHALL shift shreg left by 1 and give miso=new MSB, so each bit is stable across its master sampling rising edge.
REQ-018 In SHIFT, an sclk_fall with bit_cnt==DATA_W SHALL transition to DONE.
REQ-019 DONE SHALL last 1 cycle with tx_done=1, miso_oe=0, miso=0 and tx_busy=0, then return to IDLE.
REQ-020 ssn_rise in SHIFT SHALL transition to IDLE with tx_abort=1 for 1 cycle and miso_oe=0, and SHALL NOT pulse tx_done; ssn_rise takes priority over a simultaneous sclk_fall.
REQ-021 tx_req outside IDLE SHALL be ignored, with shreg and bit_cnt unchanged; tx_req in the DONE cycle is also ignored.
REQ-022 Edges on sclk in IDLE SHALL have no effect, and miso SHALL stay 0.
REQ-023 Latency from tx_req to a valid first bit SHALL be 1 clk, which is well before the first data-phase sclk rise (at least 5 clk).

Reset
REQ-024 On reset, the block SHALL set state=IDLE; shreg=0; bit_cnt=0; miso=0; miso_oe=0; tx_busy=0; tx_done=0; tx_abort=0; synchronizer flops: sclk chain=0, ssn chain=1.
REQ-025 Reset asserted mid-frame SHALL return all state to the reset values immediately, SHALL give no tx_done or tx_abort pulse, and the next tx_req after release SHALL start a fresh frame.

Structure
REQ-026 A shared package spi_pkg SHALL hold the FSM state enum, SPI_DATA_W=16 and SPI_HDR_BITS=16, and the receiver SHALL use the same package.
REQ-027 A single sub-module spi_sync_edge SHALL provide the synchronizer and edge detection, with one instance each for sclk and ssn, outputs rise and fall.
REQ-028 The FSM, counter and shift register SHALL be in one module with a registered miso output, and no combinational path from tx_data to miso.

Verification
REQ-029 Scenario: tx_req with tx_data=16'hA5C3, then 16 sclk periods at 10 MHz -> miso sampled on rises = 1010_0101_1100_0011; tx_done pulses once after the 16th fall; miso_oe falls with tx_done.
REQ-030 Scenario: tx_data=16'h8001, ssn raised after 5 rises -> tx_abort=1 for 1 clk, miso_oe=0, no tx_done, state IDLE.
REQ-031 Scenario: a second tx_req with 16'hFFFF at bit 7 of a 16'h0000 frame -> all 16 sampled bits = 0; the second request is ignored.
REQ-032 Scenario: reset asserted at bit 9 of 16'h1234 -> all outputs 0 within the same cycle; a following frame 16'h00FF transmits correctly.
REQ-033 Scenario: back-to-back frames 16'h0001 then 16'h8000, with ssn toggled between -> both frames are bit-exact and there are two tx_done pulses.
REQ-034 Scenario: sclk toggling in IDLE with no tx_req -> miso=0, miso_oe=0, and no tx_done pulses.
